bus_arbiter_decoder: RTL
========================

Name: bus_arbiter_decoder

Overview:
- Registered, parametrised successor to the CPU bus address decoder.
- Decodes a CPU bus request against NSLV programmable base/mask windows and drives a one-hot slave select. Runs a req/ack handshake with the selected slave and returns read data, ack, or error to the CPU.
- Sits between CPU memory stage and peripherals: RAM, LED, 7-segment, keyboard, VGA.
- Adds what the old decoder lacked: handshake, read-data mux, unmapped-address error and slave timeout.

Parameters:
- NSLV, 5, number of slave windows (1..32).
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {VGA 32'hFFF0_0000, KBD 32'hFFFF_FE00, SEG 32'hFFFF_FF10, LED 32'hFFFF_FF00, RAM 32'h0000_0000}, flattened NSLV*AW base addresses; slave 0 is in the LSBs.
- SLV_MASK, {32'hFFF0_0000, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000}, flattened NSLV*AW compare masks.
- TMO_CYCLES, 255, max ACCESS cycles before timeout; 0 disables timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- cpu_bc_req  in  1  CPU request strobe.
- cpu_bc_addr  in  AW  CPU address.
- cpu_bc_wdata  in  DW  CPU write data.
- cpu_bc_rw  in  1  1=write, 0=read.
- bc_cpu_rdata  out  DW  read data to CPU.
- bc_cpu_ack  out  1  one-cycle completion pulse.
- bc_cpu_err  out  1  error flag, valid with bc_cpu_ack.
- bc_cpu_busy  out  1  high while not IDLE.
- select  out  NSLV  one-hot slave select.
- rw  out  1  latched rw to slaves.
- bc_slv_addr  out  AW  latched address to slaves.
- bc_slv_wdata  out  DW  latched write data to slaves.
- slv_bc_rdata  in  NSLV*DW  flattened slave read data.
- slv_bc_ack  in  NSLV  per-slave completion.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. select, rw, bc_slv_addr, bc_slv_wdata, bc_cpu_rdata, bc_cpu_ack, bc_cpu_err, bc_cpu_busy, and the timeout counter all clear to 0 at the next edge. Reset mid-ACCESS abandons the transfer with no ack.
- Decode (combinational): hit[i] = ((cpu_bc_addr & MASK[i]) == BASE[i]). Lowest index wins on overlap, so LED/SEG/KBD shadow VGA by default.
- IDLE: req=1 at edge k latches addr, wdata and rw into bc_slv_*.
  - Any hit: select=onehot(winner), state=ACCESS from cycle k+1.
  - No hit: select stays 0, state=RESP, err=1.
- ACCESS: counter increments each cycle from 0.
  - slv_bc_ack[sel]=1 at an edge: capture slv_bc_rdata[sel] into bc_cpu_rdata on read (0 on write), err=0, select→0, state=RESP.
  - Acks from unselected slaves are ignored.
  - Counter reaches TMO_CYCLES-1 without ack (TMO_CYCLES≠0): rdata=0, err=1, select→0, state=RESP.
  - Ack on the same edge as timeout: ack wins, err=0.
- RESP: bc_cpu_ack=1 for exactly one cycle with err/rdata valid, then IDLE. rdata holds until the next ack.
- cpu_bc_req is ignored outside IDLE; the CPU must hold or re-issue it after ack.
- Latency: req sampled at edge k, slave acks in its first ACCESS cycle, bc_cpu_ack high in cycle k+2. Unmapped address gives ack in cycle k+1.
- bc_cpu_busy = (state≠IDLE).
- Counter width: $clog2(TMO_CYCLES+1), minimum 1. It saturates and never wraps.
- rw, bc_slv_addr and bc_slv_wdata are stable for the whole of ACCESS.

Decomposition:
- Package bus_pkg holds:
  - state enum {IDLE, ACCESS, RESP}.
  - default slave index constants SLV_RAM=0, SLV_LED=1, SLV_SEG=2, SLV_KBD=3, SLV_VGA=4.
  - default BASE/MASK constants.
- Sub-module bus_addr_decode holds the combinational mask-compare plus lowest-index priority encoder. Outputs: one-hot, hit_any, index.

Test Plan:
- Read 0x0000_0010, RAM acks in its first ACCESS cycle with 0xDEAD_BEEF → select=5'b00001 one cycle; bc_cpu_ack at k+2 with rdata=0xDEAD_BEEF, err=0.
- Write 0xFFFF_FF14 data 0x0000_00A5 → select=5'b00100, rw=1, bc_slv_wdata=0xA5; SEG acks after 3 cycles; ack with err=0, rdata=0.
- Read 0x8000_0000 (unmapped) → select stays 0; bc_cpu_ack at k+1, err=1.
- TMO_CYCLES=4, read 0xFFFF_FE04, KBD never acks → select=5'b01000 for 4 cycles; then ack with err=1, rdata=0. Stray LED ack during the wait is ignored.
- Address 0xFFFF_FF08 hits both LED and VGA → select=5'b00010 (LED wins).
- rst_n=0 in the second ACCESS cycle → next edge select=0, busy=0, no ack. A new request after reset completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default address map for the CPU bus arbiter/decoder.
// Slave indices follow the flattened-parameter order: slave 0 sits in the LSBs.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int SLV_RAM = 0;
   localparam int SLV_LED = 1;
   localparam int SLV_SEG = 2;
   localparam int SLV_KBD = 3;
   localparam int SLV_VGA = 4;

   localparam logic [5*32-1:0] DEF_SLV_BASE = {
      32'hFFF0_0000,  // VGA
      32'hFFFF_FE00,  // KBD
      32'hFFFF_FF10,  // SEG
      32'hFFFF_FF00,  // LED
      32'h0000_0000   // RAM
   };

   localparam logic [5*32-1:0] DEF_SLV_MASK = {
      32'hFFF0_0000,
      32'hFFFF_FF00,
      32'hFFFF_FFF0,
      32'hFFFF_FFF0,
      32'hFFFF_0000
   };

   // Index width for n slaves; a single slave still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask window compare with lowest-index priority.
// Overlapping windows resolve to the smallest slave index.
module bus_addr_decode
   import bus_pkg::*;
#(
   parameter int                   NSLV     = 5,
   parameter int                   AW       = 32,
   parameter logic [NSLV*AW-1:0]   SLV_BASE = DEF_SLV_BASE,
   parameter logic [NSLV*AW-1:0]   SLV_MASK = DEF_SLV_MASK,
   localparam int                  IW       = idx_width(NSLV)
) (
   input  logic [AW-1:0]   i_addr,
   output logic [NSLV-1:0] o_onehot,
   output logic            o_hit_any,
   output logic [IW-1:0]   o_idx
);

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves
      // one unassigned and no latch is inferred.
      o_onehot  = '0;
      o_hit_any = 1'b0;
      o_idx     = '0;
      // Walk from the top down so the lowest matching index is written last.
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((i_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            o_onehot    = '0;
            o_onehot[i] = 1'b1;
            o_hit_any   = 1'b1;
            o_idx       = IW'(i);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_decoder.sv
// Registered CPU bus decoder: window decode, req/ack handshake with one slave,
// read-data return, unmapped-address error and slave timeout.
module bus_arbiter_decoder
   import bus_pkg::*;
#(
   parameter int                 NSLV       = 5,
   parameter int                 AW         = 32,
   parameter int                 DW         = 32,
   parameter logic [NSLV*AW-1:0] SLV_BASE   = DEF_SLV_BASE,
   parameter logic [NSLV*AW-1:0] SLV_MASK   = DEF_SLV_MASK,
   parameter int                 TMO_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_bc_req,
   input  logic [AW-1:0]      cpu_bc_addr,
   input  logic [DW-1:0]      cpu_bc_wdata,
   input  logic               cpu_bc_rw,
   output logic [DW-1:0]      bc_cpu_rdata,
   output logic               bc_cpu_ack,
   output logic               bc_cpu_err,
   output logic               bc_cpu_busy,
   output logic [NSLV-1:0]    select,
   output logic               rw,
   output logic [AW-1:0]      bc_slv_addr,
   output logic [DW-1:0]      bc_slv_wdata,
   input  logic [NSLV*DW-1:0] slv_bc_rdata,
   input  logic [NSLV-1:0]    slv_bc_ack
);

   localparam int IW = idx_width(NSLV);
   localparam int CW = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = (TMO_CYCLES > 0) ? CW'(TMO_CYCLES - 1) : '0;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [NSLV-1:0] r_sel,   w_sel_nxt;
   logic [CW-1:0]  r_cnt,    w_cnt_nxt;
   logic [IW-1:0]  r_idx;
   logic           r_rw;
   logic [AW-1:0]  r_addr;
   logic [DW-1:0]  r_wdata;
   logic [DW-1:0]  r_rdata,  w_rdata_nxt;
   logic           r_ack;
   logic           r_err,    w_err_nxt;
   logic           w_latch;
   logic           w_done;

   logic [NSLV-1:0] w_onehot;
   logic            w_hit_any;
   logic [IW-1:0]   w_idx;
   logic            w_slv_ack;
   logic            w_tmo;
   logic [DW-1:0]   w_slv_rdata;

   bus_addr_decode #(
      .NSLV     (NSLV),
      .AW       (AW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .i_addr    (cpu_bc_addr),
      .o_onehot  (w_onehot),
      .o_hit_any (w_hit_any),
      .o_idx     (w_idx)
   );

   // Only the selected slave's ack counts; strays from others are masked off.
   assign w_slv_ack = |(slv_bc_ack & r_sel);
   assign w_tmo     = (TMO_CYCLES != 0) && (r_cnt == TMO_LAST);

   always_comb begin
      w_slv_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (r_idx == IW'(i)) w_slv_rdata = slv_bc_rdata[i*DW +: DW];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_done      = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = '0;
      case (r_state)
         IDLE: begin
            if (cpu_bc_req) begin
               w_latch   = 1'b1;
               w_cnt_nxt = '0;
               if (w_hit_any) begin
                  w_sel_nxt   = w_onehot;
                  w_state_nxt = ACCESS;
               end else begin
                  w_done      = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = RESP;
               end
            end
         end
         ACCESS: begin
            // Ack is tested first so it wins over a timeout on the same edge.
            if (w_slv_ack) begin
               w_done      = 1'b1;
               w_rdata_nxt = r_rw ? '0 : w_slv_rdata;
               w_sel_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = RESP;
            end else if (w_tmo) begin
               w_done      = 1'b1;
               w_err_nxt   = 1'b1;
               w_sel_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = RESP;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_sel <= w_sel_nxt;
         r_cnt <= w_cnt_nxt;
         r_ack <= w_done;
         if (w_latch) begin
            r_idx   <= w_idx;
            r_rw    <= cpu_bc_rw;
            r_addr  <= cpu_bc_addr;
            r_wdata <= cpu_bc_wdata;
         end
         if (w_done) begin
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
         end
      end
   end

   assign bc_cpu_rdata = r_rdata;
   assign bc_cpu_ack   = r_ack;
   assign bc_cpu_err   = r_err;
   assign bc_cpu_busy  = (r_state != IDLE);
   assign select       = r_sel;
   assign rw           = r_rw;
   assign bc_slv_addr  = r_addr;
   assign bc_slv_wdata = r_wdata;

endmodule
